// File: rtl/bw_rf_pkg.sv
// Shared types and helpers for bit-write register arrays.
// Merge is pure combinational; callers size-cast to/from BW_RF_MAX_W.
package bw_rf_pkg;

    typedef enum logic {
        RF_INIT  = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    // Widest entry any bit-write array may use with bw_merge.
    localparam int BW_RF_MAX_W = 512;

    function automatic logic [BW_RF_MAX_W-1:0] bw_merge(
        input logic [BW_RF_MAX_W-1:0] old_d,
        input logic [BW_RF_MAX_W-1:0] din,
        input logic [BW_RF_MAX_W-1:0] mask
    );
        return (old_d & ~mask) | (din & mask);
    endfunction

endpackage

// File: rtl/bw_rf_init_seq.sv
// Post-reset clear sequencer: walks every entry once, then holds READY.
// Latency: exactly DEPTH cycles after reset release; no backpressure.
module bw_rf_init_seq
    import bw_rf_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_l,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_adr,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

    rf_state_e         state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= RF_INIT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        init_we   = 1'b0;
        if (state == RF_INIT) begin
            init_we = 1'b1;
            if (idx == LAST_ADR) begin
                state_nxt = RF_READY;
                idx_nxt   = '0;
            end else begin
                idx_nxt = idx + ADDR_W'(1);
            end
        end
    end

    assign init_adr  = idx;
    assign init_done = (state == RF_READY);

endmodule

// File: rtl/bw_rf_masked_mp.sv
// Bit-masked register file: one masked write port, NUM_RD registered read ports, HW init, sticky low-region lock.
// Latency: reads 1 cycle with write-through bypass; no backpressure, every port accepts every cycle.
module bw_rf_masked_mp
    import bw_rf_pkg::*;
#(
    parameter int               DEPTH        = 32,
    parameter int               WIDTH        = 80,
    parameter int               NUM_RD       = 2,
    parameter int               LOCK_ENTRIES = 4,
    parameter logic [WIDTH-1:0] INIT_VAL     = '0,
    localparam int              ADDR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                           clk,
    input  logic                           reset_l,
    input  logic                           wr_vld,
    input  logic [ADDR_W-1:0]              wr_adr,
    input  logic [WIDTH-1:0]               wr_din,
    input  logic [WIDTH-1:0]               wr_mask,
    output logic                           wr_err,
    input  logic [NUM_RD-1:0]              rd_vld,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_adr,
    output logic [NUM_RD-1:0][WIDTH-1:0]   rd_dout,
    output logic [NUM_RD-1:0]              rd_dout_vld,
    input  logic                           lock_set,
    output logic                           locked,
    output logic                           init_done
);

    // One extra bit so DEPTH itself is representable for range compares.
    localparam int                AW1       = ADDR_W + 1;
    localparam logic [ADDR_W:0]   DEPTH_LIM = AW1'(DEPTH);
    localparam logic [ADDR_W:0]   LOCK_LIM  = AW1'(LOCK_ENTRIES);

    logic                  init_we;
    logic [ADDR_W-1:0]     init_adr;
    logic [WIDTH-1:0]      mem [DEPTH];

    logic                  wr_in_range, wr_prot, wr_drop, wr_commit;
    logic [WIDTH-1:0]      wr_old, wr_merged;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_adr;
    logic [WIDTH-1:0]      mem_dat;

    bw_rf_init_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .clk       (clk),
        .reset_l   (reset_l),
        .init_we   (init_we),
        .init_adr  (init_adr),
        .init_done (init_done)
    );

    assign wr_in_range = {1'b0, wr_adr} < DEPTH_LIM;
    assign wr_prot     = locked && ({1'b0, wr_adr} < LOCK_LIM);
    assign wr_drop     = !init_done || !wr_in_range || wr_prot;
    assign wr_commit   = wr_vld && !wr_drop;
    assign wr_old      = wr_in_range ? mem[wr_adr] : '0;
    assign wr_merged   = WIDTH'(bw_merge(BW_RF_MAX_W'(wr_old), BW_RF_MAX_W'(wr_din),
                                         BW_RF_MAX_W'(wr_mask)));

    // Init sequencer owns the write port until READY.
    always_comb begin
        mem_we  = 1'b0;
        mem_adr = wr_adr;
        mem_dat = wr_merged;
        if (init_we) begin
            mem_we  = 1'b1;
            mem_adr = init_adr;
            mem_dat = INIT_VAL;
        end else if (wr_commit) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_adr] <= mem_dat;
        end
    end

    // Lock is evaluated against this cycle's state, so a same-cycle lock_set never blocks the write.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_err <= 1'b0;
            locked <= 1'b0;
        end else begin
            wr_err <= wr_vld && wr_drop;
            if (init_done && lock_set && (LOCK_ENTRIES > 0)) begin
                locked <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic             rd_in_range;
        logic [WIDTH-1:0] rd_data;
        logic [WIDTH-1:0] dout_q;
        logic             vld_q;

        assign rd_in_range = {1'b0, rd_adr[p]} < DEPTH_LIM;

        always_comb begin
            rd_data = '0;
            if (rd_in_range) begin
                rd_data = (wr_commit && (wr_adr == rd_adr[p])) ? wr_merged : mem[rd_adr[p]];
            end
        end

        always_ff @(posedge clk or negedge reset_l) begin
            if (!reset_l) begin
                dout_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                vld_q <= init_done && rd_vld[p];
                if (init_done && rd_vld[p]) begin
                    dout_q <= rd_data;
                end
            end
        end

        assign rd_dout[p]     = dout_q;
        assign rd_dout_vld[p] = vld_q;
    end

endmodule

// File: doc/bw_rf_masked_mp.md
# bw_rf_masked_mp

Parametrised bit-masked register file: one masked write port, NUM_RD independent read ports with registered outputs and write-through bypass. Contents are cleared by a hardware init sequencer after reset. A sticky lock write-protects a low address region. Generalises the fixed 32x80 bit-write array used in the core's thread/trap-level state storage. Array state changes only under clk/reset_l; there is no local or test reset path.

## Interface
- DEPTH, 32, number of entries (need not be a power of 2)
- WIDTH, 80, bits per entry
- NUM_RD, 2, number of read ports
- LOCK_ENTRIES, 4, entries [0, LOCK_ENTRIES) protected once locked (0 disables locking)
- INIT_VAL, '0, value written to every entry during init
- clk  in  1  single clock, rising edge
- reset_l  in  1  asynchronous active-low reset
- wr_vld  in  1  write request
- wr_adr  in  ADDR_W  write address, ADDR_W = max(1, $clog2(DEPTH))
- wr_din  in  WIDTH  write data
- wr_mask  in  WIDTH  1 = take wr_din bit, 0 = keep old bit
- wr_err  out  1  one-cycle pulse, write dropped
- rd_vld  in  NUM_RD  per-port read request
- rd_adr  in  NUM_RD x ADDR_W  per-port read address
- rd_dout  out  NUM_RD x WIDTH  per-port read data, registered
- rd_dout_vld  out  NUM_RD  per-port data valid
- lock_set  in  1  request to set the lock
- locked  out  1  lock state
- init_done  out  1  array initialised, ports live

## Operation
- FSM states: INIT, READY. reset_l low: state = INIT, init index = 0, locked = 0, init_done = 0, wr_err = 0, rd_dout_vld = 0, rd_dout = 0. The array has no reset.
- INIT: each cycle write INIT_VAL to entry[index], index++. After index DEPTH-1 is written, go to READY next cycle and set init_done = 1. Init takes exactly DEPTH cycles after reset release.
- INIT: wr_vld drops the write with a wr_err pulse. Reads give rd_dout_vld = 0. lock_set is ignored.
- READY write: entry = (old & ~wr_mask) | (wr_din & wr_mask). A write with wr_mask = 0 is legal and leaves the entry unchanged.
- A write is dropped with a wr_err pulse when wr_adr >= DEPTH, or when locked and wr_adr < LOCK_ENTRIES.
- Lock: lock_set in READY sets locked = 1 on the next edge. locked is sticky until reset_l. lock_set and a protected write in the same cycle: the write commits, because the lock takes effect from the following cycle.
- Read port p, in READY with rd_vld[p]: rd_dout[p] = entry[rd_adr[p]].
  - Bypass: if the same cycle carries a committing write to the same address, rd_dout[p] returns the merged new value.
  - Out-of-range address returns 0 with valid = 1.
  - Without rd_vld, rd_dout holds and valid = 0.
- Ports are independent. All ports may read the same address.
- Reset mid-init or mid-operation aborts everything. The full DEPTH-cycle init reruns.

## Timing
- Write: commits at the clk edge where wr_vld = 1. Visible to any read issued in that cycle (bypass) or later.
- Read latency: 1 cycle, from rd_vld/rd_adr to rd_dout/rd_dout_vld.
- wr_err: asserted the cycle after the dropped request, for 1 cycle.
- init_done: rises at cycle DEPTH after reset release, counted from 0 at the first edge with reset_l high.
- No back-pressure. One write and NUM_RD reads are accepted every cycle.

## Structure
- Package bw_rf_pkg holds the state enum (RF_INIT, RF_READY) and a merge function f(old, din, mask), shared with other bit-write arrays.
- Sub-module bw_rf_init_seq: index counter, FSM and init_done. It drives the init write port muxed into the array.
- Top-level: array, masked merge, range and lock checks, read port generate loop with bypass compare.

## Test plan
- Reset release with defaults: init_done rises after 32 cycles. Every address then reads 0. wr_vld at cycle 5 gives wr_err at cycle 6.
- Write adr 7, din all-ones, mask 0x0...00FF, over an entry holding 0. Read the next cycle: 0x0...00FF. A second write with mask 0xF0...0 then sets only the top nibble.
- Write adr 3 and read adr 3 on both ports in the same cycle: both ports return the merged value 1 cycle later with valid = 1.
- lock_set, then write adr 2: wr_err pulses and data is unchanged. Write adr 4 commits. Same-cycle lock_set plus write adr 1 commits.
- DEPTH=20: write adr 25 gives wr_err. Read adr 25 returns 0 with valid.
- Assert reset_l low at init index 10 and while locked: locked = 0, init restarts, init_done after 32 cycles, all entries 0.
